// File: rtl/fpu_pkg.sv
// Shared definitions for the floating-point add/sub datapath.
//   fp_class_e    : operand class produced by fp_classify
//   Sp*/Dp*       : word, exponent and stored-significand widths for single/double precision
//   SpExpOnes/DpExpOnes : all-ones exponent (Inf/NaN encoding) per precision
package fpu_pkg;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_e;

  // Single precision
  localparam int unsigned SpW  = 32;
  localparam int unsigned SpEW = 8;
  localparam int unsigned SpSW = 23;

  // Double precision
  localparam int unsigned DpW  = 64;
  localparam int unsigned DpEW = 11;
  localparam int unsigned DpSW = 52;

  localparam logic [SpEW-1:0] SpExpOnes = '1;
  localparam logic [DpEW-1:0] DpExpOnes = '1;

endpackage

// File: rtl/fp_classify.sv
// Combinational classifier for one IEEE-754 operand.
//   exp_i  : biased exponent field
//   man_i  : stored significand field
//   cls_o  : FP_ZERO / FP_NORM / FP_INF / FP_NAN
//   sgf_o  : significand with hidden bit; denormals are flushed to zero (hidden bit 0,
//            fraction 0). Inf/NaN keep hidden bit 1 since their exponent is non-zero.
module fp_classify
  import fpu_pkg::*;
#(
  parameter int unsigned EW = 8,
  parameter int unsigned SW = 23
) (
  input  logic [EW-1:0] exp_i,
  input  logic [SW-1:0] man_i,
  output fp_class_e     cls_o,
  output logic [SW:0]   sgf_o
);

  localparam logic [EW-1:0] ExpOnes = '1;

  always_comb begin
    cls_o = FP_NORM;
    sgf_o = {1'b1, man_i};
    if (exp_i == ExpOnes) begin
      cls_o = (man_i != '0) ? FP_NAN : FP_INF;
    end else if (exp_i == '0) begin
      cls_o = FP_ZERO;
      sgf_o = '0;
    end
  end

endmodule

// File: rtl/fp_unpack_stage.sv
// Front-end unpack/align stage of the FP add/sub pipeline.
// Splits two IEEE-754 operands into sign/exponent/significand, classifies them, orders them
// by magnitude (larger first) and emits the exponent difference plus special-case flags.
// Two register stages with valid/ready backpressure:
//   S1 : decoded fields, classes, effective B sign, magnitude compare result
//   S2 : swapped outputs, exponent difference, NaN/Inf/Zero flags (drives the outputs)
// Ports:
//   clk, rst                  : clock, asynchronous active-low reset
//   in_valid_i / in_ready_o   : operand-pair handshake
//   op_a_i, op_b_i, op_sel_i  : operands and operation (0 = A+B, 1 = A-B)
//   out_valid_o / out_ready_i : result handshake
//   sign_lg_o, eff_sub_o, swap_o, exp_lg_o, exp_diff_o, sgf_lg_o, sgf_sm_o : aligned fields
//   nan_o, inf_o, zero_o      : special-case flags
module fp_unpack_stage
  import fpu_pkg::*;
#(
  parameter int unsigned W  = 32,
  parameter int unsigned EW = 8,
  parameter int unsigned SW = 23
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [W-1:0]  op_a_i,
  input  logic [W-1:0]  op_b_i,
  input  logic          op_sel_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic          sign_lg_o,
  output logic          eff_sub_o,
  output logic          swap_o,
  output logic [EW-1:0] exp_lg_o,
  output logic [EW-1:0] exp_diff_o,
  output logic [SW:0]   sgf_lg_o,
  output logic [SW:0]   sgf_sm_o,
  output logic          nan_o,
  output logic          inf_o,
  output logic          zero_o
);

  // ---------------------------------------------------------------------------------------------
  // Field extraction and classification
  // ---------------------------------------------------------------------------------------------
  logic          a_sign;
  logic          b_sign;
  logic [EW-1:0] a_exp;
  logic [EW-1:0] b_exp;
  logic [SW-1:0] a_man;
  logic [SW-1:0] b_man;
  fp_class_e     a_cls;
  fp_class_e     b_cls;
  logic [SW:0]   a_sgf;
  logic [SW:0]   b_sgf;
  logic          a_lt_b;

  assign a_sign = op_a_i[W-1];
  assign b_sign = op_b_i[W-1];
  assign a_exp  = op_a_i[W-2 -: EW];
  assign b_exp  = op_b_i[W-2 -: EW];
  assign a_man  = op_a_i[SW-1:0];
  assign b_man  = op_b_i[SW-1:0];

  fp_classify #(
    .EW (EW),
    .SW (SW)
  ) u_classify_a (
    .exp_i (a_exp),
    .man_i (a_man),
    .cls_o (a_cls),
    .sgf_o (a_sgf)
  );

  fp_classify #(
    .EW (EW),
    .SW (SW)
  ) u_classify_b (
    .exp_i (b_exp),
    .man_i (b_man),
    .cls_o (b_cls),
    .sgf_o (b_sgf)
  );

  // Magnitude compare on flushed fields; a tie keeps A as the larger operand.
  assign a_lt_b = {a_exp, a_sgf[SW-1:0]} < {b_exp, b_sgf[SW-1:0]};

  // ---------------------------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------------------------
  logic s1_valid_q;
  logic s2_valid_q;
  logic s2_load;
  logic s1_adv;
  logic s1_load;

  assign s2_load    = !s2_valid_q || out_ready_i;
  assign s1_adv     = s1_valid_q && s2_load;
  assign in_ready_o = !s1_valid_q || s1_adv;
  assign s1_load    = in_valid_i && in_ready_o;

  // ---------------------------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------------------------
  logic          s1_sign_a_q;
  logic          s1_sign_b_q;  // B sign with op_sel already applied
  logic          s1_eff_sub_q;
  logic          s1_swap_q;
  fp_class_e     s1_cls_a_q;
  fp_class_e     s1_cls_b_q;
  logic [EW-1:0] s1_exp_a_q;
  logic [EW-1:0] s1_exp_b_q;
  logic [SW:0]   s1_sgf_a_q;
  logic [SW:0]   s1_sgf_b_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q   <= 1'b0;
      s1_sign_a_q  <= 1'b0;
      s1_sign_b_q  <= 1'b0;
      s1_eff_sub_q <= 1'b0;
      s1_swap_q    <= 1'b0;
      s1_cls_a_q   <= FP_ZERO;
      s1_cls_b_q   <= FP_ZERO;
      s1_exp_a_q   <= '0;
      s1_exp_b_q   <= '0;
      s1_sgf_a_q   <= '0;
      s1_sgf_b_q   <= '0;
    end else begin
      if (in_ready_o) begin
        s1_valid_q <= in_valid_i;
      end
      if (s1_load) begin
        s1_sign_a_q  <= a_sign;
        s1_sign_b_q  <= b_sign ^ op_sel_i;
        s1_eff_sub_q <= a_sign ^ b_sign ^ op_sel_i;
        s1_swap_q    <= a_lt_b;
        s1_cls_a_q   <= a_cls;
        s1_cls_b_q   <= b_cls;
        s1_exp_a_q   <= a_exp;
        s1_exp_b_q   <= b_exp;
        s1_sgf_a_q   <= a_sgf;
        s1_sgf_b_q   <= b_sgf;
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stage 2 next-state: swap, align, special cases
  // ---------------------------------------------------------------------------------------------
  logic          sign_lg_d;
  logic [EW-1:0] exp_lg_d;
  logic [EW-1:0] exp_sm_d;
  logic [EW-1:0] exp_diff_d;
  logic [SW:0]   sgf_lg_d;
  logic [SW:0]   sgf_sm_d;
  logic          nan_d;
  logic          inf_d;
  logic          zero_d;
  logic          a_is_inf;
  logic          b_is_inf;

  assign a_is_inf = (s1_cls_a_q == FP_INF);
  assign b_is_inf = (s1_cls_b_q == FP_INF);

  always_comb begin
    exp_lg_d = s1_exp_a_q;
    exp_sm_d = s1_exp_b_q;
    sgf_lg_d = s1_sgf_a_q;
    sgf_sm_d = s1_sgf_b_q;
    if (s1_swap_q) begin
      exp_lg_d = s1_exp_b_q;
      exp_sm_d = s1_exp_a_q;
      sgf_lg_d = s1_sgf_b_q;
      sgf_sm_d = s1_sgf_a_q;
    end
    exp_diff_d = exp_lg_d - exp_sm_d;

    nan_d  = (s1_cls_a_q == FP_NAN) || (s1_cls_b_q == FP_NAN) ||
             (a_is_inf && b_is_inf && s1_eff_sub_q);
    inf_d  = !nan_d && (a_is_inf || b_is_inf);
    zero_d = (s1_cls_a_q == FP_ZERO) && (s1_cls_b_q == FP_ZERO);

    // -0 only when both effective signs are negative (round-to-nearest zero rule).
    if (zero_d) begin
      sign_lg_d = s1_sign_a_q & s1_sign_b_q;
    end else begin
      sign_lg_d = s1_swap_q ? s1_sign_b_q : s1_sign_a_q;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stage 2 registers (drive the outputs directly)
  // ---------------------------------------------------------------------------------------------
  logic          s2_sign_lg_q;
  logic          s2_eff_sub_q;
  logic          s2_swap_q;
  logic [EW-1:0] s2_exp_lg_q;
  logic [EW-1:0] s2_exp_diff_q;
  logic [SW:0]   s2_sgf_lg_q;
  logic [SW:0]   s2_sgf_sm_q;
  logic          s2_nan_q;
  logic          s2_inf_q;
  logic          s2_zero_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_q    <= 1'b0;
      s2_sign_lg_q  <= 1'b0;
      s2_eff_sub_q  <= 1'b0;
      s2_swap_q     <= 1'b0;
      s2_exp_lg_q   <= '0;
      s2_exp_diff_q <= '0;
      s2_sgf_lg_q   <= '0;
      s2_sgf_sm_q   <= '0;
      s2_nan_q      <= 1'b0;
      s2_inf_q      <= 1'b0;
      s2_zero_q     <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
      end
      if (s1_adv) begin
        s2_sign_lg_q  <= sign_lg_d;
        s2_eff_sub_q  <= s1_eff_sub_q;
        s2_swap_q     <= s1_swap_q;
        s2_exp_lg_q   <= exp_lg_d;
        s2_exp_diff_q <= exp_diff_d;
        s2_sgf_lg_q   <= sgf_lg_d;
        s2_sgf_sm_q   <= sgf_sm_d;
        s2_nan_q      <= nan_d;
        s2_inf_q      <= inf_d;
        s2_zero_q     <= zero_d;
      end
    end
  end

  assign out_valid_o = s2_valid_q;
  assign sign_lg_o   = s2_sign_lg_q;
  assign eff_sub_o   = s2_eff_sub_q;
  assign swap_o      = s2_swap_q;
  assign exp_lg_o    = s2_exp_lg_q;
  assign exp_diff_o  = s2_exp_diff_q;
  assign sgf_lg_o    = s2_sgf_lg_q;
  assign sgf_sm_o    = s2_sgf_sm_q;
  assign nan_o       = s2_nan_q;
  assign inf_o       = s2_inf_q;
  assign zero_o      = s2_zero_q;

endmodule

// File: tb/tb_fp_unpack_stage.sv
// Self-checking bench for fp_unpack_stage (single precision).
module tb_fp_unpack_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_sel;
  logic        out_valid;
  logic        out_ready;
  logic        sign_lg;
  logic        eff_sub;
  logic        swap;
  logic [7:0]  exp_lg;
  logic [7:0]  exp_diff;
  logic [23:0] sgf_lg;
  logic [23:0] sgf_sm;
  logic        nan;
  logic        inf;
  logic        zero;

  always #5 clk = ~clk;

  fp_unpack_stage #(
    .W  (32),
    .EW (8),
    .SW (23)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_a_i      (op_a),
    .op_b_i      (op_b),
    .op_sel_i    (op_sel),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sign_lg_o   (sign_lg),
    .eff_sub_o   (eff_sub),
    .swap_o      (swap),
    .exp_lg_o    (exp_lg),
    .exp_diff_o  (exp_diff),
    .sgf_lg_o    (sgf_lg),
    .sgf_sm_o    (sgf_sm),
    .nan_o       (nan),
    .inf_o       (inf),
    .zero_o      (zero)
  );

  typedef struct packed {
    logic        sign_lg;
    logic        eff_sub;
    logic        swap;
    logic [7:0]  exp_lg;
    logic [7:0]  exp_diff;
    logic [23:0] sgf_lg;
    logic [23:0] sgf_sm;
    logic        nan;
    logic        inf;
    logic        zero;
  } res_t;

  res_t act;
  assign act = {sign_lg, eff_sub, swap, exp_lg, exp_diff, sgf_lg, sgf_sm, nan, inf, zero};

  res_t exp_q[$];
  int   n_checks    = 0;
  int   n_fail      = 0;
  int   n_delivered = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Reference: IEEE field rules evaluated directly with integer magnitudes.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sel);
    res_t        r;
    logic        sa, sb, na, nb, ia, ib, za, zb;
    logic [7:0]  ea, eb;
    logic [22:0] ma, mb;
    int unsigned mag_a, mag_b;
    sa = a[31];
    sb = b[31] ^ sel;
    ea = a[30:23];
    eb = b[30:23];
    ma = (ea == 8'd0) ? 23'd0 : a[22:0];
    mb = (eb == 8'd0) ? 23'd0 : b[22:0];
    za = (ea == 8'd0);
    zb = (eb == 8'd0);
    ia = (ea == 8'hFF) && (ma == 23'd0);
    ib = (eb == 8'hFF) && (mb == 23'd0);
    na = (ea == 8'hFF) && (ma != 23'd0);
    nb = (eb == 8'hFF) && (mb != 23'd0);
    mag_a = int'(ea) * 8388608 + int'(ma);
    mag_b = int'(eb) * 8388608 + int'(mb);
    r.swap = (mag_b > mag_a);
    if (r.swap) begin
      r.exp_lg   = eb;
      r.exp_diff = eb - ea;
      r.sgf_lg   = {eb != 8'd0, mb};
      r.sgf_sm   = {ea != 8'd0, ma};
    end else begin
      r.exp_lg   = ea;
      r.exp_diff = ea - eb;
      r.sgf_lg   = {ea != 8'd0, ma};
      r.sgf_sm   = {eb != 8'd0, mb};
    end
    r.eff_sub = a[31] ^ b[31] ^ sel;
    r.nan     = na || nb || (ia && ib && r.eff_sub);
    r.inf     = !r.nan && (ia || ib);
    r.zero    = za && zb;
    r.sign_lg = r.zero ? (sa & sb) : (r.swap ? sb : sa);
    return r;
  endfunction

  // Discard expectations for pairs in flight when reset hits.
  initial forever begin
    @(negedge rst);
    exp_q.delete();
  end

  // Compare process: samples on the falling edge, handshakes complete on the next rising edge.
  initial begin
    logic stall_prev;
    res_t held;
    stall_prev = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (stall_prev) begin
          check("stall_hold", {out_valid, act}, {1'b1, held});
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_out", out_valid, 1'b0);
          end else begin
            check("result", act, exp_q.pop_front());
            n_delivered++;
          end
        end
        if (in_valid && in_ready) exp_q.push_back(model(op_a, op_b, op_sel));
        stall_prev = out_valid && !out_ready;
        held       = act;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic sel);
    op_a     = a;
    op_b     = b;
    op_sel   = sel;
    in_valid = 1'b1;
  endtask

  // Issue one pair into an empty pipe and advance to the cycle its result appears.
  task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic sel);
    drive(a, b, sel);
    step();
    in_valid = 1'b0;
    check("latency_not_early", out_valid, 1'b0);
    step();
    check("latency_two", out_valid, 1'b1);
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sel;
  } vec_t;

  vec_t vecs[10];
  int   base;
  int   sent_stream;

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_sel    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_outputs", act, '0);
    #2 rst = 1'b1;
    step();
    check("in_ready_after_rst", in_ready, 1'b1);
    check("idle_out_valid", out_valid, 1'b0);

    // 3.0 + 1.0
    send_one(32'h40400000, 32'h3F800000, 1'b0);
    check("t1_swap", swap, 1'b0);
    check("t1_exp_lg", exp_lg, 8'h80);
    check("t1_exp_diff", exp_diff, 8'd1);
    check("t1_sgf_lg", sgf_lg, 24'hC00000);
    check("t1_sgf_sm", sgf_sm, 24'h800000);
    check("t1_eff_sub", eff_sub, 1'b0);
    check("t1_sign_lg", sign_lg, 1'b0);
    check("t1_flags", {nan, inf, zero}, 3'b000);
    step();

    // 1.0 - 3.0
    send_one(32'h3F800000, 32'h40400000, 1'b1);
    check("t2_swap", swap, 1'b1);
    check("t2_sign_lg", sign_lg, 1'b1);
    check("t2_eff_sub", eff_sub, 1'b1);
    check("t2_exp_diff", exp_diff, 8'd1);
    step();

    // inf - inf, inf + inf
    send_one(32'h7F800000, 32'h7F800000, 1'b1);
    check("t3_nan", nan, 1'b1);
    check("t3_inf", inf, 1'b0);
    step();
    send_one(32'h7F800000, 32'h7F800000, 1'b0);
    check("t3b_inf", inf, 1'b1);
    check("t3b_nan", nan, 1'b0);
    check("t3b_sign_lg", sign_lg, 1'b0);
    step();

    // denormal + (-0)
    send_one(32'h00000001, 32'h80000000, 1'b0);
    check("t4_zero", zero, 1'b1);
    check("t4_sgf_lg", sgf_lg, 24'd0);
    check("t4_sgf_sm", sgf_sm, 24'd0);
    check("t4_sign_lg", sign_lg, 1'b0);
    step();

    // Backpressure: three pairs back-to-back against a stalled consumer
    out_ready = 1'b0;
    drive(32'h40000000, 32'h3F800000, 1'b0);
    step();
    drive(32'hC1200000, 32'h41200000, 1'b1);
    step();
    drive(32'h3F000000, 32'h40800000, 1'b0);
    check("bp_in_ready_low", in_ready, 1'b0);
    check("bp_out_valid", out_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_still_blocked", in_ready, 1'b0);
    end
    base      = n_delivered;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("bp_three_out", n_delivered - base, 3);
    step();
    check("bp_drained", out_valid, 1'b0);

    // Reset with two pairs in flight
    out_ready = 1'b0;
    drive(32'h3F800000, 32'h40000000, 1'b0);
    step();
    drive(32'h40400000, 32'h40800000, 1'b1);
    step();
    in_valid = 1'b0;
    check("rst_pre_full", out_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_outputs", act, '0);
    @(posedge clk);
    #2 rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst_quiet", out_valid, 1'b0);
    end

    // Directed stream with intermittent consumer stalls
    vecs[0] = '{a: 32'hC0400000, b: 32'h40000000, sel: 1'b0};
    vecs[1] = '{a: 32'h00400000, b: 32'h3F800000, sel: 1'b1};
    vecs[2] = '{a: 32'h7FC00000, b: 32'h3F800000, sel: 1'b0};
    vecs[3] = '{a: 32'h7F800000, b: 32'h42000000, sel: 1'b1};
    vecs[4] = '{a: 32'h3F800000, b: 32'h3F800000, sel: 1'b1};
    vecs[5] = '{a: 32'h80000000, b: 32'h80000000, sel: 1'b1};
    vecs[6] = '{a: 32'h80000000, b: 32'h00000000, sel: 1'b1};
    vecs[7] = '{a: 32'hFF800000, b: 32'h7F800000, sel: 1'b0};
    vecs[8] = '{a: 32'h3F800000, b: 32'hFF800000, sel: 1'b0};
    vecs[9] = '{a: 32'h00000001, b: 32'h4B000000, sel: 1'b0};
    sent_stream = 0;
    for (int i = 0; i < 10; i++) begin
      logic acc;
      drive(vecs[i].a, vecs[i].b, vecs[i].sel);
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++) begin
        out_ready = ((i + t) % 3) != 1;
        @(negedge clk);
        acc = in_ready;
        step();
      end
      if (acc) sent_stream++;
      else check("stream_accept_timeout", acc, 1'b1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) step();
    check("drain_empty", exp_q.size(), 0);
    check("delivered_total", n_delivered, 8 + sent_stream);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
